ahb_slave_if: RTL and testbench
===============================

# ahb_slave_if

AHB slave interface that sits directly downstream of the AHB master interface on the same bus. It accepts address-phase beats and checks each one for legal size, alignment and range. It then runs the data phase against a simple register/memory backend through a one-beat valid/ready port. It produces HREADYOUT and a single-bit HRESP, including the mandatory two-cycle ERROR response.

## Interface
Parameters:
- AHB_ADDR_WIDTH, 32, address bus width
- AHB_DATA_WIDTH, 32, data bus width (8..1024, power of two)
- AHB_SLV_SIZE, 4096, bytes decoded by this slave; legal offsets 0..AHB_SLV_SIZE-1
- AHB_WAIT_TIMEOUT, 6, maximum backend wait cycles before forced ERROR (used only with AHB_SLV_WAIT_EN)

Ports:
- ahb_clk_in  in  1  bus clock, all logic on rising edge
- ahb_rstn_in  in  1  reset, synchronous, active-low
- ahb_sel_in  in  1  HSEL from decoder
- ahb_addr_in  in  AHB_ADDR_WIDTH  HADDR
- ahb_trans_in  in  2  HTRANS (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
- ahb_burst_in  in  3  HBURST (informational, not checked)
- ahb_size_in  in  3  HSIZE
- ahb_write_in  in  1  HWRITE
- ahb_wdata_in  in  AHB_DATA_WIDTH  HWDATA
- ahb_ready_in  in  1  bus HREADY (muxed)
- ahb_readyout_out  out  1  HREADYOUT
- ahb_resp_out  out  1  HRESP (0 OKAY, 1 ERROR)
- ahb_rdata_out  out  AHB_DATA_WIDTH  HRDATA
- other_valid_out  out  1  backend access strobe, data-phase cycle(s)
- other_addr_out  out  AHB_ADDR_WIDTH  registered byte offset
- other_size_out  out  3  registered HSIZE
- other_write_out  out  1  registered HWRITE
- other_wdata_out  out  AHB_DATA_WIDTH  combinational copy of ahb_wdata_in
- other_rdata_in  in  AHB_DATA_WIDTH  backend read data
- other_ready_in  in  1  backend completion (used only with AHB_SLV_WAIT_EN)
- other_error_in  in  1  backend fault, valid while other_valid_out=1

## Operation
- Accept condition: ahb_sel_in && ahb_ready_in && ahb_trans_in[1].
- On accept, register addr/size/write and compute err_pending:
  - size illegal: (8<<size) > AHB_DATA_WIDTH, or
  - misaligned: addr & ((1<<size)-1) != 0, or
  - out of range: addr + (1<<size) > AHB_SLV_SIZE.
- IDLE/BUSY beats and unselected cycles accepted silently: OKAY, zero wait, no backend strobe.
- FSM states:
  - ST_IDLE: accept -> ST_ERR1 if err_pending, else ST_DATA.
  - ST_DATA: other_valid_out=1.
    - other_error_in -> ST_ERR1 (this cycle readyout=0, resp=1, counts as ERR1, next state ST_ERR2).
    - done -> re-evaluate accept (pipelined next beat) -> ST_DATA/ST_ERR1/ST_IDLE.
  - ST_ERR1: readyout=0, resp=1 -> ST_ERR2.
  - ST_ERR2: readyout=1, resp=1. A new beat may be accepted here, same rules as ST_IDLE.
- Read: ahb_rdata_out = other_rdata_in in a completing OKAY read cycle; 0 otherwise (writes, errors, idle).
- Errored beats never raise other_valid_out.

## Timing
- Reset values: readyout=1, resp=0, rdata=0, other_valid_out=0, other_addr/size/write=0, state ST_IDLE, wait counter 0.
- Reset asserted mid-transfer: next edge forces ST_IDLE. The pending beat is dropped with no backend strobe; outputs take reset values.
- Address in cycle N -> data phase in N+1. Zero-wait OKAY completes in N+1 with readyout=1.
- Back-to-back beats: accept in the completing cycle, no bubble.
- Error response: exactly two cycles, (readyout,resp) = (0,1) then (1,1).
- A beat accepted in ST_ERR2 starts its data phase the next cycle.

## Configuration
- AHB_SLV_WAIT_EN defined:
  - In ST_DATA, readyout = other_ready_in && !other_error_in; other_valid_out stays high until completion.
  - The wait counter counts cycles with other_ready_in=0. At AHB_WAIT_TIMEOUT it forces ST_ERR1.
- Undefined: other_ready_in is ignored and no counter is built. The backend must respond in the same cycle, so every OKAY data phase is exactly one cycle.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS/HBURST encodings, the same values the master uses;
  - the HRESP codes;
  - the slave FSM state constants.
- Sub-module ahb_xfer_check: combinational size/alignment/range checker taking addr and size, parameterised by width and AHB_SLV_SIZE, outputs err.

## Test plan
- Single write, addr 0x10, size 2, wdata 0xA5A5_0001 -> N+1: other_valid_out=1, other_addr_out=0x10, other_write_out=1, readyout=1, resp=0.
- Read burst of 4 SEQ beats, 0x20..0x2C, backend returns addr value -> four consecutive OKAY cycles, ahb_rdata_out 0x20,0x24,0x28,0x2C, no bubbles.
- Misaligned NONSEQ, addr 0x2, size 2 -> (readyout,resp) = (0,1) then (1,1); other_valid_out stays 0.
- Illegal size 3 with AHB_DATA_WIDTH=32, then out-of-range addr AHB_SLV_SIZE-2 with size 2 -> two separate two-cycle ERROR responses.
- With AHB_SLV_WAIT_EN:
  - other_ready_in low 3 cycles -> readyout low 3 cycles, then OKAY;
  - held low 6 cycles -> ERROR sequence.
- Reset pulse in the data-phase cycle -> next cycle readyout=1, resp=0, other_valid_out=0, state ST_IDLE.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB encodings shared by master and slave, plus slave FSM states
package ahb_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;
  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slv_state_e;
endpackage

// File: rtl/ahb_slave_if_if.sv
// ahb_slave_if_if: AHB bus signals seen by one slave, with master/slave views
interface ahb_slave_if_if #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32
) ();
  logic                      ahb_sel_in;
  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in;
  logic [1:0]                ahb_trans_in;
  logic [2:0]                ahb_burst_in;
  logic [2:0]                ahb_size_in;
  logic                      ahb_write_in;
  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in;
  logic                      ahb_ready_in;
  logic                      ahb_readyout_out;
  logic                      ahb_resp_out;
  logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out;
  modport slave (
    input  ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_burst_in, ahb_size_in,
           ahb_write_in, ahb_wdata_in, ahb_ready_in,
    output ahb_readyout_out, ahb_resp_out, ahb_rdata_out
  );
  modport master (
    output ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_burst_in, ahb_size_in,
           ahb_write_in, ahb_wdata_in, ahb_ready_in,
    input  ahb_readyout_out, ahb_resp_out, ahb_rdata_out
  );
endinterface

// File: rtl/ahb_slave_if_xfer_check.sv
// ahb_xfer_check: flags an address-phase beat with illegal size, misalignment or out-of-range offset
module ahb_xfer_check #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SLV_SIZE   = 4096
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [2:0]            size_i,
  output logic                  err_o
);
  localparam int AW1 = ADDR_WIDTH + 1;
  logic [ADDR_WIDTH-1:0] mask;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  size_bad, misaligned, out_of_range;
  always_comb begin
    size_bad     = (32'd8 << size_i) > 32'(DATA_WIDTH);
    mask         = ADDR_WIDTH'((32'd1 << size_i) - 32'd1);
    misaligned   = |(addr_i & mask);
    end_addr     = {1'b0, addr_i} + AW1'(32'd1 << size_i);
    out_of_range = end_addr > AW1'(SLV_SIZE);
    err_o        = size_bad | misaligned | out_of_range;
  end
endmodule

// File: rtl/ahb_slave_if.sv
// ahb_slave_if: AHB slave front end driving a one-beat backend, with two-cycle ERROR response.
// Define AHB_SLV_WAIT_EN to let the backend stretch the data phase via other_ready_in.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH   = 32,
  parameter int AHB_DATA_WIDTH   = 32,
  parameter int AHB_SLV_SIZE     = 4096,
  parameter int AHB_WAIT_TIMEOUT = 6
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rstn_in,
  ahb_slave_if_if.slave             bus,
  output logic                      other_valid_out,
  output logic [AHB_ADDR_WIDTH-1:0] other_addr_out,
  output logic [2:0]                other_size_out,
  output logic                      other_write_out,
  output logic [AHB_DATA_WIDTH-1:0] other_wdata_out,
  input  logic [AHB_DATA_WIDTH-1:0] other_rdata_in,
  input  logic                      other_ready_in,
  input  logic                      other_error_in
);
  slv_state_e                state_q, state_d;
  logic [AHB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]                size_q, size_d;
  logic                      write_q, write_d;
  logic                      accept, in_data, err_now, done, take, chk_err;
  ahb_xfer_check #(
    .ADDR_WIDTH(AHB_ADDR_WIDTH),
    .DATA_WIDTH(AHB_DATA_WIDTH),
    .SLV_SIZE  (AHB_SLV_SIZE)
  ) u_check (
    .addr_i(bus.ahb_addr_in),
    .size_i(bus.ahb_size_in),
    .err_o (chk_err)
  );
`ifdef AHB_SLV_WAIT_EN
  localparam int WCW = $clog2(AHB_WAIT_TIMEOUT + 1);
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           timeout;
  // The low-ready cycle that reaches the limit is itself the first ERROR cycle
  always_comb begin
    timeout = in_data & ~other_ready_in & (wcnt_q == WCW'(AHB_WAIT_TIMEOUT - 1));
    err_now = in_data & (other_error_in | timeout);
    done    = in_data & other_ready_in & ~err_now;
    wcnt_d  = (in_data & ~other_ready_in & ~err_now) ? wcnt_q + WCW'(1) : '0;
  end
  always_ff @(posedge ahb_clk_in)
    wcnt_q <= !ahb_rstn_in ? '0 : wcnt_d;
  logic unused;
  assign unused = ^{bus.ahb_burst_in, bus.ahb_trans_in[0]};
`else
  always_comb begin
    err_now = in_data & other_error_in;
    done    = in_data & ~other_error_in;
  end
  logic unused;
  assign unused = ^{bus.ahb_burst_in, bus.ahb_trans_in[0], other_ready_in};
`endif
  always_comb begin
    accept  = bus.ahb_sel_in & bus.ahb_ready_in & bus.ahb_trans_in[1];
    take    = accept & (state_q == ST_IDLE | state_q == ST_ERR2 | done);
    state_d = err_now               ? ST_ERR2 :
              state_q == ST_ERR1    ? ST_ERR2 :
              (in_data & ~done)     ? ST_DATA :
              take                  ? (chk_err ? ST_ERR1 : ST_DATA) : ST_IDLE;
    addr_d  = take ? bus.ahb_addr_in  : addr_q;
    size_d  = take ? bus.ahb_size_in  : size_q;
    write_d = take ? bus.ahb_write_in : write_q;
  end
  assign in_data              = state_q == ST_DATA;
  assign bus.ahb_readyout_out = in_data ? done : state_q != ST_ERR1;
  assign bus.ahb_resp_out     = (err_now | state_q == ST_ERR1 | state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.ahb_rdata_out    = (done & ~write_q) ? other_rdata_in : '0;
  assign other_valid_out      = in_data;
  assign other_addr_out       = addr_q;
  assign other_size_out       = size_q;
  assign other_write_out      = write_q;
  assign other_wdata_out      = bus.ahb_wdata_in;
  always_ff @(posedge ahb_clk_in) begin
    if (!ahb_rstn_in) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end
endmodule

// File: tb/tb_ahb_slave_if.sv
// tb_ahb_slave_if: directed stimulus with a cycle-stamped expectation queue and a decoupled monitor
module tb_ahb_slave_if;
  import ahb_pkg::*;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SLV = 4096;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  ahb_slave_if_if #(.AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW)) bus ();
  logic          other_valid, other_write, other_ready, other_error;
  logic [AW-1:0] other_addr;
  logic [2:0]    other_size;
  logic [DW-1:0] other_wdata, other_rdata;
  assign bus.ahb_ready_in = bus.ahb_readyout_out;
  assign other_rdata = other_addr;
  ahb_slave_if #(
    .AHB_ADDR_WIDTH(AW), .AHB_DATA_WIDTH(DW), .AHB_SLV_SIZE(SLV), .AHB_WAIT_TIMEOUT(6)
  ) dut (
    .ahb_clk_in     (clk),
    .ahb_rstn_in    (rstn),
    .bus            (bus),
    .other_valid_out(other_valid),
    .other_addr_out (other_addr),
    .other_size_out (other_size),
    .other_write_out(other_write),
    .other_wdata_out(other_wdata),
    .other_rdata_in (other_rdata),
    .other_ready_in (other_ready),
    .other_error_in (other_error)
  );
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int fails = 0;
  typedef struct {
    int          cyc;
    logic [2:0]  ctl;
    logic [31:0] rdata;
    logic        ca;
    logic [31:0] a;
    logic        w;
    logic        cw;
    logic [31:0] wd;
    string       name;
  } exp_t;
  exp_t q[$];
  task automatic expect_at(input int dc, input logic [2:0] ctl, input logic [31:0] rd, input string name,
                           input logic ca = 1'b0, input logic [31:0] a = 32'h0, input logic w = 1'b0,
                           input logic cw = 1'b0, input logic [31:0] wd = 32'h0);
    exp_t e;
    e.cyc = cyc + dc; e.ctl = ctl; e.rdata = rd; e.name = name;
    e.ca = ca; e.a = a; e.w = w; e.cw = cw; e.wd = wd;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        logic [2:0] got;
        logic       ok;
        got = {bus.ahb_readyout_out, bus.ahb_resp_out, other_valid};
        ok  = (q[i].cyc == cyc) && (got === q[i].ctl) && (bus.ahb_rdata_out === q[i].rdata) &&
              (!q[i].ca || (other_addr === q[i].a && other_write === q[i].w)) &&
              (!q[i].cw || other_wdata === q[i].wd);
        checks++;
        if (!ok) begin
          fails++;
          $display("FAIL %s cyc %0d: got rdy/resp/vld=%b rdata=%h addr=%h wr=%b wdata=%h, expected %b rdata=%h addr=%h wr=%b wdata=%h",
                   q[i].name, cyc, got, bus.ahb_rdata_out, other_addr, other_write, other_wdata,
                   q[i].ctl, q[i].rdata, q[i].a, q[i].w, q[i].wd);
        end
        q.delete(i);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] tr, input logic [31:0] a = 32'h0, input logic [2:0] sz = 3'd2,
                       input logic w = 1'b0, input logic sel = 1'b1);
    bus.ahb_sel_in   = sel;
    bus.ahb_trans_in = tr;
    bus.ahb_addr_in  = a;
    bus.ahb_size_in  = sz;
    bus.ahb_write_in = w;
    bus.ahb_burst_in = HBURST_SINGLE;
  endtask
  initial begin
    bus.ahb_wdata_in = '0;
    other_ready = 1'b1;
    other_error = 1'b0;
    drive(HTRANS_IDLE, 32'h0, 3'd0, 1'b0, 1'b0);
    step();
    expect_at(0, 3'b100, 32'h0, "reset_state", 1'b1, 32'h0, 1'b0);
    step();
    rstn = 1'b1;
    step();
    // single write
    drive(HTRANS_NONSEQ, 32'h10, 3'd2, 1'b1);
    expect_at(1, 3'b101, 32'h0, "single_write", 1'b1, 32'h10, 1'b1, 1'b1, 32'hA5A5_0001);
    step();
    drive(HTRANS_IDLE);
    bus.ahb_wdata_in = 32'hA5A5_0001;
    expect_at(1, 3'b100, 32'h0, "idle_after_write");
    step();
    drive(HTRANS_BUSY, 32'h14);
    expect_at(1, 3'b100, 32'h0, "busy_no_strobe");
    step();
    drive(HTRANS_NONSEQ, 32'h18, 3'd2, 1'b0, 1'b0);
    expect_at(1, 3'b100, 32'h0, "unselected");
    step();
    // four-beat read burst, backend echoes the offset
    for (int i = 0; i < 4; i++) begin
      drive(i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h20 + 32'(4 * i), 3'd2, 1'b0);
      bus.ahb_burst_in = HBURST_INCR4;
      expect_at(1, 3'b101, 32'h20 + 32'(4 * i), $sformatf("rd_burst%0d", i), 1'b1, 32'h20 + 32'(4 * i), 1'b0);
      step();
    end
    drive(HTRANS_IDLE);
    expect_at(1, 3'b100, 32'h0, "burst_end");
    step();
    // misaligned
    drive(HTRANS_NONSEQ, 32'h2, 3'd2, 1'b0);
    expect_at(1, 3'b010, 32'h0, "misalign_err1");
    expect_at(2, 3'b110, 32'h0, "misalign_err2");
    expect_at(3, 3'b100, 32'h0, "misalign_idle");
    step();
    drive(HTRANS_IDLE);
    step();
    step();
    // illegal size, then beats accepted in ERR2
    drive(HTRANS_NONSEQ, 32'h0, 3'd3, 1'b0);
    expect_at(1, 3'b010, 32'h0, "size_err1");
    expect_at(2, 3'b110, 32'h0, "size_err2");
    step();
    drive(HTRANS_IDLE);
    step();
    drive(HTRANS_NONSEQ, 32'(SLV - 2), 3'd2, 1'b0);
    expect_at(1, 3'b010, 32'h0, "range_err1");
    expect_at(2, 3'b110, 32'h0, "range_err2");
    step();
    drive(HTRANS_IDLE);
    step();
    drive(HTRANS_NONSEQ, 32'(SLV), 3'd2, 1'b1);
    expect_at(1, 3'b010, 32'h0, "range_aligned_err1");
    expect_at(2, 3'b110, 32'h0, "range_aligned_err2");
    step();
    drive(HTRANS_IDLE);
    step();
    drive(HTRANS_NONSEQ, 32'(SLV - 4), 3'd2, 1'b0);
    expect_at(1, 3'b101, 32'(SLV - 4), "top_word_from_err2", 1'b1, 32'(SLV - 4), 1'b0);
    step();
    // pipelined bad beat right behind a good one
    drive(HTRANS_NONSEQ, 32'h70, 3'd2, 1'b0);
    expect_at(1, 3'b101, 32'h70, "pipe_ok", 1'b1, 32'h70, 1'b0);
    expect_at(2, 3'b010, 32'h0, "pipe_err1");
    expect_at(3, 3'b110, 32'h0, "pipe_err2");
    step();
    drive(HTRANS_NONSEQ, 32'h71, 3'd2, 1'b0);
    step();
    drive(HTRANS_IDLE);
    step();
    step();
    // backend error on a read
    drive(HTRANS_NONSEQ, 32'h40, 3'd2, 1'b0);
    expect_at(1, 3'b011, 32'h0, "backend_err1", 1'b1, 32'h40, 1'b0);
    expect_at(2, 3'b110, 32'h0, "backend_err2");
    expect_at(3, 3'b100, 32'h0, "backend_idle");
    step();
    drive(HTRANS_IDLE);
    other_error = 1'b1;
    step();
    other_error = 1'b0;
    step();
    step();
`ifdef AHB_SLV_WAIT_EN
    drive(HTRANS_NONSEQ, 32'h50, 3'd2, 1'b0);
    for (int k = 1; k <= 3; k++) expect_at(k, 3'b001, 32'h0, $sformatf("wait_%0d", k));
    expect_at(4, 3'b101, 32'h50, "wait_done", 1'b1, 32'h50, 1'b0);
    step();
    drive(HTRANS_IDLE);
    other_ready = 1'b0;
    step();
    step();
    step();
    other_ready = 1'b1;
    step();
    drive(HTRANS_NONSEQ, 32'h60, 3'd2, 1'b0);
    for (int k = 1; k <= 5; k++) expect_at(k, 3'b001, 32'h0, $sformatf("tmo_wait_%0d", k));
    expect_at(6, 3'b011, 32'h0, "tmo_err1");
    expect_at(7, 3'b110, 32'h0, "tmo_err2");
    step();
    drive(HTRANS_IDLE);
    other_ready = 1'b0;
    for (int k = 0; k < 6; k++) step();
    other_ready = 1'b1;
    step();
    step();
`endif
    // reset in the data-phase cycle
    drive(HTRANS_NONSEQ, 32'h30, 3'd2, 1'b1);
    expect_at(1, 3'b101, 32'h0, "pre_reset_dphase", 1'b1, 32'h30, 1'b1);
    expect_at(2, 3'b100, 32'h0, "reset_mid", 1'b1, 32'h0, 1'b0);
    expect_at(3, 3'b100, 32'h0, "after_reset");
    step();
    drive(HTRANS_IDLE);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    step();
    step();
    step();
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
